// File: rtl/ping_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : ping_burst_gen
// Purpose  : Serially configured burst/listen sequencer feeding the transducer
//            delay chain. Optional macro ARPAS_CONT_PING_EN enables
//            back-to-back pings while PADORUN is held high.
// Revision : 1.0 - initial release
// ============================================================================
module ping_burst_gen #(
    parameter int HP_W   = 16,
    parameter int CYC_W  = 8,
    parameter int LSN_W  = 8,
    parameter int SYNC_N = 2
) (
    input  logic ISYSCLK,
    input  logic RSTALLD,
    input  logic REGDATA,
    input  logic REGCLKS,
    input  logic AREGSEL,
    input  logic PADORUN,
    output logic FWRWRDD,
    output logic NEXTSIG,
    output logic PNGBUSY
);

    localparam int c_CFG_W = CYC_W + LSN_W;
    localparam int c_CNT_W = HP_W + 1;
    localparam int c_LCN_W = LSN_W + 8;

    localparam int c_BIT_DATA = 0;
    localparam int c_BIT_CLK  = 1;
    localparam int c_BIT_SEL  = 2;
    localparam int c_BIT_PING = 3;

    localparam logic [c_CNT_W-1:0] c_HP_ONE  = c_CNT_W'(1);
    localparam logic [CYC_W-1:0]   c_CYC_ONE = CYC_W'(1);
    localparam logic [c_LCN_W-1:0] c_LSN_ONE = c_LCN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_LISTEN = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers: all four inputs share one chain depth
    // ------------------------------------------------------------------
    logic [3:0] async_in_d;
    logic [3:0] sync_q [SYNC_N];
    logic [3:0] edge_q;
    logic [3:0] sync_last_d;

    assign async_in_d  = {PADORUN, AREGSEL, REGCLKS, REGDATA};
    assign sync_last_d = sync_q[SYNC_N-1];

    always_ff @(posedge ISYSCLK) begin
        if (RSTALLD) begin
            for (int i = 0; i < SYNC_N; i++) begin
                sync_q[i] <= '0;
            end
            edge_q <= '0;
        end else begin
            sync_q[0] <= async_in_d;
            for (int i = 1; i < SYNC_N; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            edge_q <= sync_last_d;
        end
    end

    logic regclk_rise_d;
    logic regdata_d;
    logic regsel_d;
    logic ping_rise_d;

    // Data and select come from the edge-detect stage, one clock behind the
    // strobe, so they are taken as they stood just before the strobe rose.
    assign regclk_rise_d = sync_last_d[c_BIT_CLK] & ~edge_q[c_BIT_CLK];
    assign regdata_d     = edge_q[c_BIT_DATA];
    assign regsel_d      = edge_q[c_BIT_SEL];
    assign ping_rise_d   = sync_last_d[c_BIT_PING] & ~edge_q[c_BIT_PING];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             state_q;
    logic [HP_W-1:0]    halfper_q;
    logic [c_CFG_W-1:0] burstcfg_q;
    logic [c_CNT_W-1:0] h_q;
    logic [c_CNT_W-1:0] hp_cnt_q;
    logic [CYC_W-1:0]   cyc_cnt_q;
    logic [c_LCN_W-1:0] lsn_cnt_q;
    logic               fwr_q;
    logic               nextsig_q;
    logic               busy_q;

    // Ping launch values derived from the live configuration
    logic [c_CNT_W-1:0] start_h_d;
    logic [CYC_W-1:0]   start_n_d;
    logic [c_LCN_W-1:0] start_lsn_d;
    state_t             start_state_d;
    logic               start_now_d;

    assign start_h_d   = {1'b0, halfper_q} + c_HP_ONE;
    assign start_n_d   = burstcfg_q[c_CFG_W-1:LSN_W];
    assign start_lsn_d = {burstcfg_q[LSN_W-1:0], 8'h00};

    always_comb begin
        if (start_n_d != '0) begin
            start_state_d = ST_BURST;
        end else if (start_lsn_d != '0) begin
            start_state_d = ST_LISTEN;
        end else begin
            start_state_d = ST_DONE;
        end
    end

    always_comb begin
        start_now_d = (state_q == ST_IDLE) && ping_rise_d;
`ifdef ARPAS_CONT_PING_EN
        if ((state_q == ST_DONE) && sync_last_d[c_BIT_PING]) begin
            start_now_d = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Configuration shift registers and ping sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge ISYSCLK) begin
        if (RSTALLD) begin
            state_q    <= ST_IDLE;
            halfper_q  <= '0;
            burstcfg_q <= '0;
            h_q        <= '0;
            hp_cnt_q   <= '0;
            cyc_cnt_q  <= '0;
            lsn_cnt_q  <= '0;
            fwr_q      <= 1'b0;
            nextsig_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (regclk_rise_d) begin
                if (regsel_d) begin
                    burstcfg_q <= {burstcfg_q[c_CFG_W-2:0], regdata_d};
                end else begin
                    halfper_q <= {halfper_q[HP_W-2:0], regdata_d};
                end
            end

            nextsig_q <= 1'b0;

            if (start_now_d) begin
                state_q   <= start_state_d;
                h_q       <= start_h_d;
                hp_cnt_q  <= start_h_d;
                cyc_cnt_q <= start_n_d;
                lsn_cnt_q <= start_lsn_d;
                fwr_q     <= (start_state_d == ST_BURST);
                nextsig_q <= (start_state_d == ST_DONE);
                busy_q    <= 1'b1;
            end else begin
                case (state_q)
                    ST_BURST: begin
                        if (hp_cnt_q == c_HP_ONE) begin
                            hp_cnt_q <= h_q;
                            if (fwr_q) begin
                                fwr_q <= 1'b0;
                            end else if (cyc_cnt_q == c_CYC_ONE) begin
                                // Listen count was preloaded at launch
                                if (lsn_cnt_q != '0) begin
                                    state_q <= ST_LISTEN;
                                end else begin
                                    state_q   <= ST_DONE;
                                    nextsig_q <= 1'b1;
                                end
                            end else begin
                                cyc_cnt_q <= cyc_cnt_q - c_CYC_ONE;
                                fwr_q     <= 1'b1;
                            end
                        end else begin
                            hp_cnt_q <= hp_cnt_q - c_HP_ONE;
                        end
                    end
                    ST_LISTEN: begin
                        if (lsn_cnt_q == c_LSN_ONE) begin
                            state_q   <= ST_DONE;
                            nextsig_q <= 1'b1;
                        end else begin
                            lsn_cnt_q <= lsn_cnt_q - c_LSN_ONE;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign FWRWRDD = fwr_q;
    assign NEXTSIG = nextsig_q;
    assign PNGBUSY = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ping_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ping_burst_gen
// Purpose  : Directed self-checking bench for ping_burst_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ping_burst_gen;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic regdata = 1'b0;
    logic regclks = 1'b0;
    logic aregsel = 1'b0;
    logic padorun = 1'b0;
    logic fwrwrdd;
    logic nextsig;
    logic pngbusy;

    ping_burst_gen dut (
        .ISYSCLK (clk),
        .RSTALLD (rst),
        .REGDATA (regdata),
        .REGCLKS (regclks),
        .AREGSEL (aregsel),
        .PADORUN (padorun),
        .FWRWRDD (fwrwrdd),
        .NEXTSIG (nextsig),
        .PNGBUSY (pngbusy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] fwr_vec;
    int          hi_cnt;
    int          rises;
    int          ns_at;
    int          ns_cnt;
    int          busy_first;
    int          busy_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One serial write, MSB first; data settles before each strobe rise
    task automatic shift_reg(input logic sel, input logic [15:0] val);
        for (int b = 15; b >= 0; b--) begin
            @(negedge clk);
            aregsel = sel;
            regdata = val[b];
            repeat (2) @(negedge clk);
            regclks = 1'b1;
            repeat (4) @(negedge clk);
            regclks = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    // Raise PADORUN now (at a negedge), drop it at sample 'hold', and record
    // the output trace; sample k is the k-th negedge after the request.
    task automatic run_ping(input int hold, input int max_cyc);
        logic prev;
        prev       = 1'b0;
        fwr_vec    = '0;
        hi_cnt     = 0;
        rises      = 0;
        ns_at      = -1;
        ns_cnt     = 0;
        busy_first = -1;
        busy_last  = -1;
        padorun    = 1'b1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (k == hold) padorun = 1'b0;
            if (k <= 32) fwr_vec[32-k] = fwrwrdd;
            if (fwrwrdd) hi_cnt++;
            if (fwrwrdd && !prev) rises++;
            prev = fwrwrdd;
            if (nextsig) begin
                ns_cnt++;
                if (ns_at < 0) ns_at = k;
            end
            if (pngbusy) begin
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
            if ((ns_at > 0) && (k >= ns_at + 3)) break;
        end
    endtask

    initial begin
        int first_hi;
        int first_lo;
        int cont_ns;
        int cont_first;
        int cont_busy;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_fwr",  fwrwrdd, 0);
        check("reset_ns",   nextsig, 0);
        check("reset_busy", pngbusy, 0);

        // H=4, N=2, L=1
        shift_reg(1'b0, 16'h0003);
        shift_reg(1'b1, 16'h0201);
        run_ping(4, 400);
        check("p1_pattern", fwr_vec, 32'h3C3C0000);
        check("p1_hi_cnt",  hi_cnt, 8);
        check("p1_rises",   rises, 2);
        check("p1_ns_at",   ns_at, 275);
        check("p1_ns_cnt",  ns_cnt, 1);
        check("p1_busy_first", busy_first, 3);
        check("p1_busy_last",  busy_last, 275);

        // N=0, L=0: straight to DONE
        shift_reg(1'b1, 16'h0000);
        run_ping(4, 40);
        check("z_ns_at",     ns_at, 3);
        check("z_hi_cnt",    hi_cnt, 0);
        check("z_busy_first", busy_first, 3);
        check("z_busy_last", busy_last, 3);

        // H=1, N=3: toggles every clock
        shift_reg(1'b0, 16'h0000);
        shift_reg(1'b1, 16'h0300);
        run_ping(4, 40);
        check("h0_pattern", fwr_vec, 32'h2A000000);
        check("h0_rises",   rises, 3);
        check("h0_ns_at",   ns_at, 9);
        check("h0_busy_last", busy_last, 9);

        // Second request and HALFPER rewrite while busy
        shift_reg(1'b0, 16'h0003);
        shift_reg(1'b1, 16'h0A01);
        fork
            run_ping(4, 400);
            begin
                repeat (6) @(negedge clk);
                padorun = 1'b1;
                repeat (3) @(negedge clk);
                padorun = 1'b0;
                shift_reg(1'b0, 16'h0001);
            end
        join
        check("busy_pattern", fwr_vec, 32'h3C3C3C3C);
        check("busy_hi_cnt",  hi_cnt, 40);
        check("busy_rises",   rises, 10);
        check("busy_ns_at",   ns_at, 339);
        check("busy_ns_cnt",  ns_cnt, 1);
        check("busy_no_requeue", busy_last, 339);

        run_ping(4, 400);
        check("newh_pattern", fwr_vec, 32'h33333333);
        check("newh_hi_cnt",  hi_cnt, 20);
        check("newh_ns_at",   ns_at, 299);

        // Reset during LISTEN
        padorun = 1'b1;
        repeat (3) @(negedge clk);
        padorun = 1'b0;
        repeat (97) @(negedge clk);
        check("rst_pre_busy", pngbusy, 1);
        check("rst_pre_fwr",  fwrwrdd, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_fwr",  fwrwrdd, 0);
        check("rst_ns",   nextsig, 0);
        check("rst_busy", pngbusy, 0);
        run_ping(4, 40);
        check("rst_cfg_ns_at",  ns_at, 3);
        check("rst_cfg_hi_cnt", hi_cnt, 0);
        check("rst_cfg_ns_cnt", ns_cnt, 1);

        // PADORUN held high: H=1, N=2, L=0
        shift_reg(1'b0, 16'h0000);
        shift_reg(1'b1, 16'h0200);
        cont_ns    = 0;
        cont_first = -1;
        cont_busy  = -1;
        padorun    = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (nextsig) begin
                cont_ns++;
                if (cont_first < 0) cont_first = k;
            end
            if (pngbusy) cont_busy = k;
        end
        padorun = 1'b0;
        check("cont_first_ns", cont_first, 7);
`ifdef ARPAS_CONT_PING_EN
        check("cont_ns_cnt",    cont_ns, 7);
        check("cont_busy_last", cont_busy, 40);
`else
        check("cont_ns_cnt",    cont_ns, 1);
        check("cont_busy_last", cont_busy, 7);
`endif
        repeat (20) @(negedge clk);

        // Maximum half-period: 65536 clocks high with no wrap
        shift_reg(1'b0, 16'hFFFF);
        shift_reg(1'b1, 16'h01FF);
        first_hi = -1;
        first_lo = -1;
        padorun  = 1'b1;
        for (int k = 1; k <= 66000; k++) begin
            @(negedge clk);
            if (k == 4) padorun = 1'b0;
            if (fwrwrdd && (first_hi < 0)) first_hi = k;
            if (!fwrwrdd && (first_hi > 0)) begin
                first_lo = k;
                break;
            end
        end
        check("max_first_hi", first_hi, 3);
        check("max_first_lo", first_lo, 65539);
        check("max_busy",     pngbusy, 1);
        check("max_ns",       nextsig, 0);
        repeat (300) @(negedge clk);
        check("max_low_fwr",  fwrwrdd, 0);
        check("max_low_busy", pngbusy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("max_abort_busy", pngbusy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
